// File: rtl/irq_pkg.sv
// Shared types and constants for the trap/interrupt sequencer.
// State encoding, cause codes, default vectors and the vector helper.
// Imported by irq_pending and interrupt_controller.
package irq_pkg;

  // Two-state sequencer: no nesting of handlers.
  typedef enum logic {
    ST_USER    = 1'b0,
    ST_HANDLER = 1'b1
  } state_t;

  // Cause code for ecall; irq i reports i+1.
  localparam int unsigned CAUSE_ECALL = 0;

  // Default vector locations.
  localparam logic [31:0] DEF_VEC_BASE  = 32'h0000_0100;
  localparam logic [31:0] DEF_ECALL_VEC = 32'h0000_0200;

  // Handler address for irq idx: base + 4*idx, 32-bit modulo.
  function automatic logic [31:0] irq_vector(input logic [31:0] base,
                                             input logic [31:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/irq_pending.sv
// Rising-edge detect, sticky pending bits and lowest-index priority pick.
// Latency: an edge sampled at clock k is visible as pending after edge k.
// Backpressure: none; edges are latched every cycle, ack clears the taken bit.
module irq_pending
  import irq_pkg::*;
#(
  parameter int NUM_IRQ = 3,
  parameter int IDX_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] ack,
  output logic               any_pending,
  output logic [IDX_W-1:0]   sel_idx
);

  logic [NUM_IRQ-1:0] r_irq_prev;
  logic [NUM_IRQ-1:0] r_pending;
  logic [NUM_IRQ-1:0] w_edge;

  assign w_edge = irq_in & ~r_irq_prev;

  // Track previous levels and accumulate edges; a new edge beats its own ack.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_irq_prev <= '0;
      r_pending  <= '0;
    end else begin
      r_irq_prev <= irq_in;
      r_pending  <= (r_pending & ~ack) | w_edge;
    end
  end

  assign any_pending = |r_pending;

  // Priority encoder: scan high to low so the lowest set index wins.
  always_comb begin
    sel_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (r_pending[i]) begin
        sel_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Trap/interrupt sequencer: redirects the PC into handlers and back on uret.
// Latency: redirect and ack are combinational in the retiring cycle.
// Backpressure: nothing advances while retire is low; edges are still latched.
module interrupt_controller
  import irq_pkg::*;
#(
  parameter int          NUM_IRQ   = 3,
  parameter logic [31:0] VEC_BASE  = DEF_VEC_BASE,
  parameter logic [31:0] ECALL_VEC = DEF_ECALL_VEC
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [NUM_IRQ-1:0]           irq_in,
  input  logic                         retire,
  input  logic                         ecall,
  input  logic                         uret,
  input  logic [31:0]                  pc_cur,
  input  logic [31:0]                  pc_next,
  output logic                         pc_sel,
  output logic [31:0]                  pc_target,
  output logic [31:0]                  epc,
  output logic [$clog2(NUM_IRQ+1)-1:0] cause,
  output logic                         in_handler,
  output logic [NUM_IRQ-1:0]           irq_ack
);

  localparam int IDX_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam int CAUSE_W = $clog2(NUM_IRQ + 1);

  state_t               r_state;
  logic [31:0]          r_epc;
  logic [CAUSE_W-1:0]   r_cause;

  logic                 w_any_pending;
  logic [IDX_W-1:0]     w_sel_idx;
  logic                 w_pc_sel;
  logic [31:0]          w_pc_target;
  logic [NUM_IRQ-1:0]   w_ack;

  irq_pending #(
    .NUM_IRQ (NUM_IRQ),
    .IDX_W   (IDX_W)
  ) u_pending (
    .CLK         (CLK),
    .RST         (RST),
    .irq_in      (irq_in),
    .ack         (w_ack),
    .any_pending (w_any_pending),
    .sel_idx     (w_sel_idx)
  );

  // Redirect mux and ack: ecall beats irqs in USER, uret returns from HANDLER.
  always_comb begin
    w_pc_sel    = 1'b0;
    w_pc_target = pc_next;
    w_ack       = '0;
    if (!RST && retire) begin
      if (r_state == ST_USER) begin
        if (ecall) begin
          w_pc_sel    = 1'b1;
          w_pc_target = ECALL_VEC;
        end else if (w_any_pending) begin
          w_pc_sel    = 1'b1;
          w_pc_target = irq_vector(VEC_BASE, 32'(w_sel_idx));
          w_ack       = NUM_IRQ'(1) << w_sel_idx;
        end
      end else if (uret) begin
        w_pc_sel    = 1'b1;
        w_pc_target = r_epc;
      end
    end
  end

  // Sequencer state plus saved return address and cause, advanced on retire.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_USER;
      r_epc   <= '0;
      r_cause <= '0;
    end else if (retire) begin
      if (r_state == ST_USER) begin
        if (ecall) begin
          r_epc   <= pc_cur + 32'd4;
          r_cause <= CAUSE_W'(CAUSE_ECALL);
          r_state <= ST_HANDLER;
        end else if (w_any_pending) begin
          // Current instruction completes, so resume at its successor.
          r_epc   <= pc_next;
          r_cause <= CAUSE_W'(w_sel_idx) + CAUSE_W'(1);
          r_state <= ST_HANDLER;
        end
      end else if (uret) begin
        r_state <= ST_USER;
      end
    end
  end

  assign pc_sel     = w_pc_sel;
  assign pc_target  = w_pc_target;
  assign irq_ack    = w_ack;
  assign epc        = r_epc;
  assign cause      = r_cause;
  assign in_handler = (r_state == ST_HANDLER);

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Trap and interrupt sequencer for the single-cycle RISC-V core. It consumes the `ecall`/`uret` decode strobes from the hardwired controller and asynchronous request lines from peripherals such as the key and timer. It redirects the PC into a handler and saves the return address. On `uret` it redirects the PC back. It sits beside the PC-select mux, and its redirect overrides the datapath's sequential or branch next-PC.

## Interface
Parameters:
- `NUM_IRQ`, 3: number of external request lines; line 0 has the highest priority.
- `VEC_BASE`, 32'h0000_0100: vector for irq i is `VEC_BASE + 4*i`.
- `ECALL_VEC`, 32'h0000_0200: vector for `ecall`.

Ports:
- `CLK`, in, 1: the single clock; all state updates on the rising edge.
- `RST`, in, 1: reset, synchronous and active-high.
- `irq_in`, in, NUM_IRQ: request lines, rising-edge sensitive.
- `retire`, in, 1: the current instruction completes this cycle (low while halted).
- `ecall`, in, 1: decode strobe from the hardwired controller.
- `uret`, in, 1: decode strobe from the hardwired controller.
- `pc_cur`, in, 32: PC of the current instruction.
- `pc_next`, in, 32: datapath next PC, including branch and jump.
- `pc_sel`, out, 1: 1 means the PC register loads `pc_target` instead of `pc_next`.
- `pc_target`, out, 32: redirect address.
- `epc`, out, 32: saved return address.
- `cause`, out, $clog2(NUM_IRQ+1): 0 for ecall, i+1 for irq i.
- `in_handler`, out, 1: the state is HANDLER.
- `irq_ack`, out, NUM_IRQ: one-hot pulse in the cycle irq i is taken.

## Operation
- **State machine:** two states, USER and HANDLER; there is no nesting.
- **Edge detect:** `edge = irq_in & ~irq_prev`, and `irq_prev <= irq_in` every cycle.
- **Pending register:** `pending <= (pending & ~irq_ack) | edge`. When a source's new edge coincides with its own ack, the set wins.
- **In USER with `retire`=1** (first match applies):
  - `ecall`=1:
    - `pc_sel`=1, `pc_target`=ECALL_VEC.
    - `epc<=pc_cur+4`, `cause<=0`.
    - Go to HANDLER.
    - Pending irqs stay pending.
  - Otherwise, if `pending`≠0:
    - Select the lowest index i.
    - `pc_sel`=1, `pc_target`=VEC_BASE+4i, `irq_ack[i]`=1.
    - `epc<=pc_next`: the current instruction completes, including a taken branch.
    - `cause<=i+1`.
    - Go to HANDLER.
  - `uret` in USER is ignored: `pc_sel`=0.
- **In HANDLER with `retire`=1:**
  - `uret`=1: `pc_sel`=1, `pc_target`=epc, go to USER. `epc` and `cause` keep their values.
  - `ecall` is ignored: `pc_sel`=0, no state change.
  - Pending irqs accumulate and are not taken.
- **`retire`=0:** `pc_sel`=0, no state, epc, cause or ack change. Edges are still latched.
- **Default outputs:** `pc_target` = `pc_next` whenever `pc_sel`=0.
- **Arithmetic:** all additions are 32-bit modulo; `pc_cur+4` wraps at 2^32.

## Timing
- **Registered state:** state, pending, irq_prev, epc and cause.
- **Mealy outputs:** `pc_sel`, `pc_target` and `irq_ack` are combinational in the same cycle as `retire`/`ecall`/`uret`.
- **IRQ latency:**
  - A rising edge on `irq_in` sampled at edge k sets pending after edge k.
  - The redirect comes no earlier than the cycle following edge k, if in USER with `retire`.
  - The PC equals the vector after the next edge.
- **After `uret`:** the instruction at epc always executes before any pending irq is taken. This guarantees forward progress.
- **Reset:** state=USER, pending=0, irq_prev=0, epc=0, cause=0. `pc_sel`=0 and `irq_ack`=0 while `RST`=1, which overrides all other inputs.
  - A line already high when reset releases counts as one edge.
  - Reset while in HANDLER discards the saved epc and all pending requests.

## Structure
- **Package `irq_pkg`:**
  - state enum (USER, HANDLER);
  - cause code constants;
  - default vector constants.
- **Sub-module `irq_pending`:** NUM_IRQ-wide edge detect, pending register and priority encoder. Outputs are `any_pending` and `sel_idx`; input is `ack` one-hot.
- The top level holds the FSM, epc and cause, and the redirect mux.

## Test plan
- **Reset then ecall:** reset; `pc_cur`=0x40, `ecall`=1, `retire`=1 → `pc_sel`=1, `pc_target`=0x200. Next cycle `epc`=0x44, `cause`=0, `in_handler`=1.
- **Priority:** `irq_in`=3'b110 rises; next cycle, `retire`=1, `pc_next`=0x80 → `irq_ack`=3'b010, `pc_target`=0x104, `epc`=0x80, `cause`=2. `pending[2]` remains.
- **uret and forward progress:** in HANDLER with `epc`=0x80 and `pending[2]` set, `uret` → `pc_target`=0x80, state USER. The next cycle (`pc_cur`=0x80) takes irq 2: `pc_target`=0x108, `epc`=that cycle's `pc_next`.
- **Ecall beats irq:** same cycle as `pending[0]`=1 and `ecall`=1 → ECALL_VEC taken, `irq_ack`=0. `pending[0]` stays set.
- **Stall and ignored strobes:** `retire`=0 with `ecall`=1 → `pc_sel`=0, state unchanged. In USER, `uret`=1 → `pc_sel`=0. A level held high on `irq_in` gives one ack only.
- **Reset mid-handler:** in HANDLER with `pending`=3'b100, assert `RST` for one cycle → `in_handler`=0, `epc`=0, no ack afterward unless a new edge arrives.
